// File: rtl/data_memory_param.sv
// Byte-addressable little-endian data memory with sized/extended accesses,
// configurable read latency and misalignment / out-of-range error pulses.
module data_memory_param #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int DEPTH_BYTES  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  misaligned_err,
    output logic                  range_err
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int LAT_W = 4;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  mis_q, mis_d;
    logic                  rng_q, rng_d;
    logic [7:0]            mem_q [DEPTH_BYTES];

    logic                  wr_en;
    logic                  resp;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            rd_size;
    logic                  rd_uns;
    logic [DATA_WIDTH-1:0] rd_raw;
    logic [DATA_WIDTH-1:0] rd_ext;

    function automatic logic is_mis(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] s);
        logic [ADDR_WIDTH-1:0] m;
        m = (ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1);
        return (a & m) != '0;
    endfunction

    // End address is formed one bit wider so addresses near the top cannot wrap.
    function automatic logic is_oor(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] s);
        logic [AW1-1:0] end_a;
        end_a = {1'b0, a} + (AW1'(1) << s);
        return end_a > AW1'(DEPTH_BYTES);
    endfunction

    // With single-cycle latency the response is built from the live request.
    always_comb begin
        if (state_q == S_WAIT) begin
            rd_addr = addr_q;
            rd_size = size_q;
            rd_uns  = uns_q;
        end else begin
            rd_addr = address;
            rd_size = size;
            rd_uns  = is_unsigned;
        end
    end

    always_comb begin
        rd_raw = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << rd_size))
                rd_raw[8*i +: 8] = mem_q[rd_addr[IDX_W-1:0] + IDX_W'(i)];
        end
        case (rd_size)
            2'd0:    rd_ext = rd_uns ? {56'b0, rd_raw[7:0]}  : {{56{rd_raw[7]}},  rd_raw[7:0]};
            2'd1:    rd_ext = rd_uns ? {48'b0, rd_raw[15:0]} : {{48{rd_raw[15]}}, rd_raw[15:0]};
            2'd2:    rd_ext = rd_uns ? {32'b0, rd_raw[31:0]} : {{32{rd_raw[31]}}, rd_raw[31:0]};
            default: rd_ext = rd_raw;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        size_d   = size_q;
        uns_d    = uns_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        mis_d    = 1'b0;
        rng_d    = 1'b0;
        wr_en    = 1'b0;
        resp     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemWrite) begin
                    if (is_mis(address, size))
                        mis_d = 1'b1;
                    else if (is_oor(address, size))
                        rng_d = 1'b1;
                    else
                        wr_en = 1'b1;
                end else if (MemRead) begin
                    addr_d = address;
                    size_d = size;
                    uns_d  = is_unsigned;
                    if (READ_LATENCY <= 1) begin
                        resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    resp    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (resp) begin
            rvalid_d = 1'b1;
            if (is_mis(rd_addr, rd_size)) begin
                mis_d   = 1'b1;
                rdata_d = '0;
            end else if (is_oor(rd_addr, rd_size)) begin
                rng_d   = 1'b1;
                rdata_d = '0;
            end else begin
                rdata_d = rd_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            rng_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            mis_q    <= mis_d;
            rng_q    <= rng_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++)
                mem_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << size))
                    mem_q[address[IDX_W-1:0] + IDX_W'(i)] <= write_data[8*i +: 8];
            end
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign read_data      = rdata_q;
    assign read_valid     = rvalid_q;
    assign misaligned_err = mis_q;
    assign range_err      = rng_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: a latency-3 instance and a latency-1 instance
// share stimulus and are checked against a byte-array reference model.
module tb_data_memory_param;

    localparam int LAT   = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, en_l1 = 1'b1;
    logic [63:0] address = '0, write_data = '0;
    logic [1:0]  size = '0;
    logic        is_unsigned = 1'b0;

    logic        rr3, rv3, mis3, rng3, rr1, rv1, mis1, rng1;
    logic [63:0] rd3, rd1;
    logic        mr1, mw1;

    int checks = 0;
    int errors = 0;
    bit [7:0] mem_m [DEPTH];

    assign mr1 = mem_read & en_l1;
    assign mw1 = mem_write & en_l1;

    always #5 clk = ~clk;

    data_memory_param #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT)) dut3 (
        .clk(clk), .reset_n(reset_n), .MemRead(mem_read), .MemWrite(mem_write),
        .address(address), .write_data(write_data), .size(size), .is_unsigned(is_unsigned),
        .req_ready(rr3), .read_data(rd3), .read_valid(rv3),
        .misaligned_err(mis3), .range_err(rng3));

    data_memory_param #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH_BYTES(DEPTH), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .MemRead(mr1), .MemWrite(mw1),
        .address(address), .write_data(write_data), .size(size), .is_unsigned(is_unsigned),
        .req_ready(rr1), .read_data(rd1), .read_valid(rv1),
        .misaligned_err(mis1), .range_err(rng1));

    function automatic void model_calc(input logic [63:0] a, input logic [1:0] s, input logic u,
                                       output logic [63:0] exp, output logic em, output logic er);
        int sb;
        logic [64:0] end_a;
        logic [63:0] raw;
        sb    = 1 << s;
        end_a = {1'b0, a} + 65'(sb);
        em    = (a % 64'(sb)) != 0;
        er    = !em && (end_a > 65'(DEPTH));
        exp   = '0;
        if (!em && !er) begin
            raw = '0;
            for (int i = 0; i < sb; i++)
                raw = raw | (64'(mem_m[int'(a) + i]) << (8 * i));
            if (!u && sb < 8 && raw[8*sb-1])
                raw = raw | ~((64'd1 << (8 * sb)) - 64'd1);
            exp = raw;
        end
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        for (int i = 0; i < (1 << s); i++)
            mem_m[int'(a) + i] = d[8*i +: 8];
    endfunction

    task automatic do_read(input logic [63:0] a, input logic [1:0] s, input logic u);
        logic [63:0] exp;
        logic em, er;
        model_calc(a, s, u, exp, em, er);
        @(negedge clk);
        address = a; size = s; is_unsigned = u; mem_read = 1'b1;
        @(posedge clk);
        #1 mem_read = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            checks++;
            if (rv3 !== (c == LAT)) begin
                errors++; $display("FAIL rd_valid3 a=%0h c=%0d got=%b exp=%b", a, c, rv3, (c == LAT));
            end
            checks++;
            if (rr3 !== (c == LAT)) begin
                errors++; $display("FAIL rd_ready3 a=%0h c=%0d got=%b exp=%b", a, c, rr3, (c == LAT));
            end
            checks++;
            if (rv1 !== (c == 1)) begin
                errors++; $display("FAIL rd_valid1 a=%0h c=%0d got=%b exp=%b", a, c, rv1, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (rd1 !== exp || mis1 !== em || rng1 !== er) begin
                    errors++;
                    $display("FAIL rd_resp1 a=%0h s=%0d u=%b got=%h/%b/%b exp=%h/%b/%b",
                             a, s, u, rd1, mis1, rng1, exp, em, er);
                end
            end
            if (c == LAT) begin
                checks++;
                if (rd3 !== exp || mis3 !== em || rng3 !== er) begin
                    errors++;
                    $display("FAIL rd_resp3 a=%0h s=%0d u=%b got=%h/%b/%b exp=%h/%b/%b",
                             a, s, u, rd3, mis3, rng3, exp, em, er);
                end
            end
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        logic [63:0] exp;
        logic em, er;
        model_calc(a, s, 1'b1, exp, em, er);
        @(negedge clk);
        address = a; size = s; write_data = d; mem_write = 1'b1;
        @(posedge clk);
        #1 mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (mis3 !== em || rng3 !== er || mis1 !== em || rng1 !== er || rv3 !== 1'b0 || rv1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_err a=%0h s=%0d got=%b%b%b%b%b%b exp=%b%b%b%b00",
                     a, s, mis3, rng3, mis1, rng1, rv3, rv1, em, er, em, er);
        end
        @(negedge clk);
        checks++;
        if (mis3 !== 1'b0 || rng3 !== 1'b0 || rr3 !== 1'b1) begin
            errors++; $display("FAIL wr_pulse_len a=%0h got=%b%b%b exp=001", a, mis3, rng3, rr3);
        end
        if (!em && !er) model_write(a, d, s);
    endtask

    task automatic test_reset;
        checks++;
        if (rr3 !== 1'b1 || rv3 !== 1'b0 || rd3 !== 64'h0 || mis3 !== 1'b0 || rng3 !== 1'b0 ||
            rr1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 64'h0 || mis1 !== 1'b0 || rng1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%b%b%h%b%b exp=10%h00", rr3, rv3, rd3, mis3, rng3, 64'h0);
        end
        do_read(64'd3, 2'd3, 1'b0);
        do_read(64'd8, 2'd3, 1'b0);
    endtask

    task automatic test_sizes;
        do_write(64'd8, 64'hDEADBEEFCAFEBABE, 2'd3);
        do_read(64'd8, 2'd3, 1'b0);
        do_read(64'd8, 2'd0, 1'b1);
        do_read(64'd8, 2'd0, 1'b0);
        do_read(64'd12, 2'd2, 1'b0);
        do_read(64'd12, 2'd2, 1'b1);
        do_write(64'd10, 64'h1234, 2'd1);
        do_read(64'd8, 2'd3, 1'b1);
        do_read(64'd10, 2'd1, 1'b0);
        do_read(64'd9, 2'd1, 1'b0);
    endtask

    task automatic test_latency;
        logic [63:0] exp;
        logic em, er;
        do_write(64'd16, 64'h0123456789ABCDEF, 2'd3);
        model_calc(64'd16, 2'd3, 1'b0, exp, em, er);
        @(negedge clk);
        address = 64'd16; size = 2'd3; mem_read = 1'b1;
        @(posedge clk);
        #1 mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (rr3 !== 1'b0 || rv3 !== 1'b0) begin
            errors++; $display("FAIL lat_c1 got=%b%b exp=00", rr3, rv3);
        end
        en_l1 = 1'b0; write_data = 64'h5555AAAA5555AAAA; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0; en_l1 = 1'b1;
        checks++;
        if (rr3 !== 1'b0 || rv3 !== 1'b0) begin
            errors++; $display("FAIL lat_c2 got=%b%b exp=00", rr3, rv3);
        end
        @(negedge clk);
        checks++;
        if (rr3 !== 1'b1 || rv3 !== 1'b1 || rd3 !== exp) begin
            errors++; $display("FAIL lat_c3 got=%b%b%h exp=11%h", rr3, rv3, rd3, exp);
        end
        do_read(64'd16, 2'd3, 1'b0);
    endtask

    task automatic test_range;
        do_write(64'd1020, 64'h1111111111111111, 2'd3);
        do_write(64'd1016, 64'hA5A5A5A5F0F0F0F0, 2'd3);
        do_write(64'd1024, 64'h2222222222222222, 2'd3);
        do_write(64'hFFFFFFFFFFFFFFF8, 64'h3333333333333333, 2'd3);
        do_write(64'd1023, 64'h80, 2'd0);
        do_write(64'd1024, 64'h44, 2'd0);
        do_read(64'd1016, 2'd3, 1'b0);
        do_read(64'd1023, 2'd0, 1'b0);
        do_read(64'd1022, 2'd2, 1'b0);
        do_read(64'd1024, 2'd2, 1'b1);
        do_read(64'hFFFFFFFFFFFFFFF8, 2'd3, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  s;
            logic [63:0] a, d;
            s = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << s) - 64'd1);
            if ($urandom_range(0, 15) == 0) a = a + 64'hFFFFFFFFFFFFF000;
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) do_write(a, d, s);
            else do_read(a, s, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_both;
        logic [63:0] exp;
        logic em, er;
        model_calc(64'd32, 2'd3, 1'b0, exp, em, er);
        @(negedge clk);
        address = 64'd32; size = 2'd3; write_data = 64'hFEEDFACE00C0FFEE;
        mem_read = 1'b1; mem_write = 1'b1;
        @(posedge clk);
        #1 mem_read = 1'b0; mem_write = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            checks++;
            if (rv3 !== 1'b0 || rv1 !== 1'b0 || rr3 !== 1'b1) begin
                errors++; $display("FAIL both_no_read c=%0d got=%b%b%b exp=001", c, rv3, rv1, rr3);
            end
        end
        model_write(64'd32, 64'hFEEDFACE00C0FFEE, 2'd3);
        do_read(64'd32, 2'd3, 1'b0);
    endtask

    task automatic test_reset_in_wait;
        do_write(64'd40, 64'h0BADF00D0BADF00D, 2'd3);
        @(negedge clk);
        address = 64'd40; size = 2'd3; mem_read = 1'b1;
        @(posedge clk);
        #1 mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            checks++;
            if (rv3 !== 1'b0 || rr3 !== 1'b1 || rd3 !== 64'h0) begin
                errors++; $display("FAIL rst_wait c=%0d got=%b%b%h exp=10%h", c, rv3, rr3, rd3, 64'h0);
            end
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h0;
        do_read(64'd40, 2'd3, 1'b0);
        do_read(64'd8, 2'd3, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_sizes;
        test_latency;
        test_range;
        test_random;
        test_both;
        test_reset_in_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
